// File: rtl/multi_timer_if.sv
// Control/status bundle for multi_timer: period load port, per-channel strobes and status.
// MULTI_TIMER_PAUSE_EN adds the per-channel pause input.
interface multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              load_valid;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_period;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] periodic;
`ifdef MULTI_TIMER_PAUSE_EN
  logic [NUM_CH-1:0] pause;
`endif
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] done;
  logic              tick;

  modport master (
    output load_valid, load_ch, load_period, start, stop, periodic,
`ifdef MULTI_TIMER_PAUSE_EN
    output pause,
`endif
    input  running, expired, done, tick
  );

  modport slave (
    input  load_valid, load_ch, load_period, start, stop, periodic,
`ifdef MULTI_TIMER_PAUSE_EN
    input  pause,
`endif
    output running, expired, done, tick
  );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel interval timer: one shared prescaler tick drives NUM_CH one-shot/periodic
// down-counters. Optional per-channel pause is enabled with MULTI_TIMER_PAUSE_EN.
module multi_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int CLK_FREQUENCY  = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int DEFAULT_PERIOD = 2
) (
  input  logic         clk,
  input  logic         reset,
  multi_timer_if.slave bus
);
  localparam int TICK_DIV = CLK_FREQUENCY / TICK_HZ;
  localparam int PRESC_W  = $clog2(TICK_DIV);
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   period_q [NUM_CH];
  logic [CNT_W-1:0]   period_d [NUM_CH];
  logic [CNT_W-1:0]   count_q [NUM_CH];
  logic [CNT_W-1:0]   count_d [NUM_CH];
  logic [NUM_CH-1:0]  mode_q, mode_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  expired_q, expired_d;
  logic [NUM_CH-1:0]  hold;
  logic [NUM_CH-1:0]  running_w;

`ifdef MULTI_TIMER_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = '0;
`endif

  // tick is registered, so it is high in the cycle after the counter sits at TICK_DIV-1
  always_comb begin
    presc_d = (presc_q == PRESC_W'(TICK_DIV - 1)) ? '0 : presc_q + PRESC_W'(1);
    tick_d  = (presc_q == PRESC_W'(TICK_DIV - 1));
  end

  always_comb begin
    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    mode_d    = mode_q;
    done_d    = done_q;
    expired_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];

      // Out-of-range channel numbers never match any i, so they are dropped here.
      if (bus.load_valid && (bus.load_ch == CH_W'(i)))
        period_d[i] = bus.load_period;

      // Priority: stop > start > tick. Start and reload read the old period_q.
      if (bus.stop[i]) begin
        state_d[i] = IDLE;
        count_d[i] = '0;
        done_d[i]  = 1'b0;
      end else if (bus.start[i] && (period_q[i] != '0)) begin
        state_d[i] = RUN;
        count_d[i] = period_q[i];
        mode_d[i]  = bus.periodic[i];
        done_d[i]  = 1'b0;
      end else if ((state_q[i] == RUN) && tick_q && !hold[i]) begin
        if (count_q[i] == CNT_W'(1)) begin
          expired_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = period_q[i];
          end else begin
            state_d[i] = IDLE;
            count_d[i] = '0;
            done_d[i]  = 1'b1;
          end
        end else begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here, so every register samples the pre-edge values.
    if (reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      mode_q    <= '0;
      done_q    <= '0;
      expired_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        // NOTE: the period array is reset on purpose, since the channels must restart from DEFAULT_PERIOD.
        period_q[i] <= CNT_W'(DEFAULT_PERIOD);
      end
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      expired_q <= expired_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  always_comb begin
    running_w = '0;
    for (int i = 0; i < NUM_CH; i++)
      running_w[i] = (state_q[i] == RUN);
  end

  assign bus.running = running_w;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;
  assign bus.tick    = tick_q;

endmodule
